sprite_region_fill: RTL
=======================

# sprite_region_fill

Parametrised rectangle filler for the framebuffer write port: on a `start` pulse it latches a top-left corner and a fill colour, then streams one pixel write per accepted cycle over a `SPRITE_W` × `SPRITE_H` region in row-major order. It is used to erase a sprite's previous position, or paint a solid block, before the sprite renderer draws the new frame. It sits between the game logic, which issues the requests, and the framebuffer write arbiter, which provides backpressure through `wr_ready`.

## Interface
- `SPRITE_W`, 16: region width in pixels (1..64)
- `SPRITE_H`, 16: region height in pixels (1..64)
- `SCREEN_W`, 640: visible columns; used for clipping
- `SCREEN_H`, 480: visible rows; used for clipping
- `PIXEL_W`, 8: pixel data width
- `clock` in 1: system clock, all logic on the rising edge
- `reset` in 1: synchronous, active-low reset
- `start` in 1: request pulse; accepted only while `ready`=1
- `x` in 10: top-left column, sampled on acceptance
- `y` in 10: top-left row, sampled on acceptance
- `fill_color` in PIXEL_W: colour to write, sampled on acceptance (0 = erase)
- `wr_ready` in 1: the arbiter accepts the current write this cycle
- `ready` out 1: the block is idle and can accept `start`
- `done` out 1: one-cycle pulse after the last pixel of a region is retired
- `data_out` out PIXEL_W: pixel value
- `x_out` out 10: write column
- `y_out` out 10: write row
- `write_enable` out 1: `data_out`, `x_out` and `y_out` form a valid write

## Operation
- FSM states: IDLE, FILL, DONE.
- **IDLE**
  - `ready`=1.
  - If `start`=1: latch `x`, `y` and `fill_color`; clear `col` and `row`; go to FILL.
- **FILL**
  - Present the pixel at (`x_base`+`col`, `y_base`+`row`) on registered outputs.
  - A pixel *retires* when `write_enable`=1 and `wr_ready`=1, or when it is clipped (see Configuration). Clipped pixels retire unconditionally in 1 cycle.
  - Retiring advances `col`. When `col` wraps at `SPRITE_W`-1 it resets to 0 and `row` increments.
  - Retiring pixel (`SPRITE_W`-1, `SPRITE_H`-1) moves the FSM to DONE.
  - While `wr_ready`=0 and the pixel is not clipped, the outputs and counters hold.
- **DONE**
  - `done`=1 and `write_enable`=0 for exactly 1 cycle, then return to IDLE.
- `start` is ignored outside IDLE; it is not queued.
- Arithmetic:
  - `col` and `row` are `$clog2` of the dimension, with a minimum of 1 bit.
  - The coordinate sum is computed in 11 bits.
  - `x_out` and `y_out` carry the low 10 bits.
- `data_out` equals the latched `fill_color` throughout FILL.

## Timing
- Reset, applied on any cycle including mid-FILL, gives:
  - state = IDLE
  - `ready`=1
  - `done`=0, `write_enable`=0
  - `data_out`=0, `x_out`=0, `y_out`=0
  - counters = 0
- The first write is presented in the cycle after `start` is accepted (1-cycle latency).
- With `wr_ready` held at 1 and no clipping:
  - FILL lasts `SPRITE_W`·`SPRITE_H` cycles.
  - `done` is asserted in cycle `SPRITE_W`·`SPRITE_H`+1 after acceptance.
  - `ready` returns 1 cycle after that.
- The minimum spacing between two accepted `start` pulses is `SPRITE_W`·`SPRITE_H`+2 cycles.
- `wr_ready` is combinational from the arbiter. The block does not depend on it to drive `write_enable`, so there is no combinational loop.

## Configuration
- Macro: `SPRITE_REGION_FILL_CLIP_EN`.
- **Defined:**
  - A pixel is clipped when its 11-bit column sum ≥ `SCREEN_W` or its 11-bit row sum ≥ `SCREEN_H`.
  - During a clipped pixel, `write_enable`=0; the pixel still occupies 1 cycle.
- **Undefined:**
  - No pixel is ever clipped. Every pixel is written with the truncated 10-bit coordinates, which may wrap past 1023 or land off-screen.
  - All retirements require `wr_ready`.

## Test plan
- Basic erase, defaults:
  - Stimulus: `x`=100, `y`=50, `fill_color`=0, `wr_ready`=1.
  - Response: 256 writes, first (100,50), 17th (100,51), last (115,65).
  - `done` asserted in cycle 257 after acceptance; `ready` returns in cycle 258.
- Backpressure:
  - Stimulus: `wr_ready` low on cycles 3–5 of FILL.
  - Response: the outputs hold at (102,50) for 4 cycles; the total write count is still 256, with no duplicated or skipped coordinate.
- Clipping, macro defined:
  - Stimulus: `x`=632, `y`=472, 16×16.
  - Response: exactly 64 writes, covering columns 632–639 and rows 472–479; `done` still asserted 257 cycles after acceptance.
- Non-square parameters:
  - Stimulus: `SPRITE_W`=5, `SPRITE_H`=3, `fill_color`=8'hA5.
  - Response: 15 writes with `data_out`=8'hA5, row-major order.
- Mid-operation reset:
  - Stimulus: `reset`=0 on FILL cycle 40.
  - Response: the next cycle has all outputs 0 and `ready`=1.
  - A new `start` is accepted immediately and begins again at `col`=0, `row`=0.
- Ignored start:
  - Stimulus: `start` pulsed in FILL with `x`=0.
  - Response: the coordinates continue from the original region, and no extra `done` appears.

Source files
------------

// File: rtl/sprite_region_fill.sv
// Rectangle filler: streams SPRITE_W x SPRITE_H pixel writes of one colour, row-major, from a latched corner.
// Latency: first write presented 1 cycle after start; done pulses 1 cycle after the last pixel retires.
// Backpressure: wr_ready low holds outputs and counters; clipped pixels (SPRITE_REGION_FILL_CLIP_EN) retire regardless.
//
// Ports: clock/reset (sync, active-low); start/x/y/fill_color request, accepted while ready=1;
//        wr_ready from the framebuffer arbiter; data_out/x_out/y_out/write_enable registered write;
//        done one-cycle completion pulse.
// Optional feature macro: SPRITE_REGION_FILL_CLIP_EN (off-screen pixels are skipped instead of written).
module sprite_region_fill #(
   parameter int SPRITE_W = 16,
   parameter int SPRITE_H = 16,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int PIXEL_W  = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [9:0]         x,
   input  logic [9:0]         y,
   input  logic [PIXEL_W-1:0] fill_color,
   input  logic               wr_ready,
   output logic               ready,
   output logic               done,
   output logic [PIXEL_W-1:0] data_out,
   output logic [9:0]         x_out,
   output logic [9:0]         y_out,
   output logic               write_enable
);

   localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      col_q, col_d;
   logic [RW-1:0]      row_q, row_d;
   logic [9:0]         x_base_q, x_base_d;
   logic [9:0]         y_base_q, y_base_d;
   logic [PIXEL_W-1:0] data_out_q, data_out_d;
   logic [9:0]         x_out_q, x_out_d;
   logic [9:0]         y_out_q, y_out_d;
   logic               we_q, we_d;

   logic               clipped;
   logic               retire;
   logic               load_pix;
   logic               clip_nx;
   logic [10:0]        x_sum;
   logic [10:0]        y_sum;

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      x_base_d   = x_base_q;
      y_base_d   = y_base_q;
      data_out_d = data_out_q;
      x_out_d    = x_out_q;
      y_out_d    = y_out_q;
      we_d       = we_q;
      load_pix   = 1'b0;

`ifdef SPRITE_REGION_FILL_CLIP_EN
      // In FILL, write_enable is low only while the presented pixel is off-screen.
      clipped = (state_q == ST_FILL) && !we_q;
`else
      clipped = 1'b0;
`endif
      retire = (state_q == ST_FILL) && ((we_q && wr_ready) || clipped);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               x_base_d   = x;
               y_base_d   = y;
               data_out_d = fill_color;
               col_d      = '0;
               row_d      = '0;
               state_d    = ST_FILL;
               load_pix   = 1'b1;
            end
         end
         ST_FILL: begin
            if (retire) begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) begin
                     state_d = ST_DONE;
                     we_d    = 1'b0;
                  end else begin
                     row_d    = row_q + 1'b1;
                     load_pix = 1'b1;
                  end
               end else begin
                  col_d    = col_q + 1'b1;
                  load_pix = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Coordinates of the pixel to present next cycle, from the next-state counters
      // so the registered outputs line up with the counters.
      x_sum = {1'b0, x_base_d} + 11'(col_d);
      y_sum = {1'b0, y_base_d} + 11'(row_d);
`ifdef SPRITE_REGION_FILL_CLIP_EN
      clip_nx = (x_sum >= 11'(SCREEN_W)) || (y_sum >= 11'(SCREEN_H));
`else
      clip_nx = 1'b0;
`endif
      if (load_pix) begin
         x_out_d = x_sum[9:0];
         y_out_d = y_sum[9:0];
         we_d    = !clip_nx;
      end
   end

   // Carry bits and screen size only matter when clipping is compiled in.
   logic unused_ok;
   assign unused_ok = ^{x_sum[10], y_sum[10], 11'(SCREEN_W), 11'(SCREEN_H)};

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         col_q      <= '0;
         row_q      <= '0;
         x_base_q   <= '0;
         y_base_q   <= '0;
         data_out_q <= '0;
         x_out_q    <= '0;
         y_out_q    <= '0;
         we_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         x_base_q   <= x_base_d;
         y_base_q   <= y_base_d;
         data_out_q <= data_out_d;
         x_out_q    <= x_out_d;
         y_out_q    <= y_out_d;
         we_q       <= we_d;
      end
   end

   assign ready        = (state_q == ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign data_out     = data_out_q;
   assign x_out        = x_out_q;
   assign y_out        = y_out_q;
   assign write_enable = we_q;

endmodule
